// File: rtl/bot_batch_emitter_pkg.sv
// rtl/bot_batch_emitter_pkg.sv - shared widths and state type for the bot batch emitter
package bot_batch_emitter_pkg;

    localparam int BOT_WIDTH    = 128;
    localparam int PERMUTE_W    = 6;
    localparam int BATCH_SIZE_W = 6;

    typedef enum logic {
        RUN         = 1'b0,
        CREDIT_WAIT = 1'b1
    } emitter_state_t;

endpackage

// File: rtl/bot_emitter_credit_counter.sv
// rtl/bot_emitter_credit_counter.sv - outstanding-batch counter with floor saturation and full flags
module bot_emitter_credit_counter #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CREDIT_W        = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CREDIT_W-1:0] o_count,
    output logic                o_full,
    output logic                o_full_next
);

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_OUTSTANDING);

    logic [CREDIT_W-1:0] r_count;
    logic [CREDIT_W-1:0] w_next;
    logic                w_dec_eff;

    // A finish pulse with nothing in flight is ignored so the count never wraps below zero
    always_comb begin
        w_dec_eff = i_dec && (r_count != '0);
        w_next    = r_count;
        if (i_inc && !w_dec_eff) begin
            w_next = r_count + 1'b1;
        end else if (!i_inc && w_dec_eff) begin
            w_next = r_count - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count     = r_count;
    assign o_full      = (r_count == MAX_C);
    assign o_full_next = (w_next == MAX_C);

endmodule

// File: rtl/bot_batch_emitter.sv
// rtl/bot_batch_emitter.sv - batch-splitting, credit-limited bot source for one permutator lane (optional BOT_EMITTER_STATS_EN)
module bot_batch_emitter
    import bot_batch_emitter_pkg::*;
#(
    parameter int MAX_BATCH_SIZE  = 63,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CREDIT_W        = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BOT_WIDTH-1:0] inBot,
    input  logic [PERMUTE_W-1:0] inValidPermutes,
    input  logic                 inLast,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [BOT_WIDTH-1:0] outBot,
    output logic [PERMUTE_W-1:0] outValidPermutes,
    output logic                 outBatchDone,
    input  logic                 slowDownInput,
    input  logic                 batchFinishedIn,
    output logic [CREDIT_W-1:0]  outstanding,
`ifdef BOT_EMITTER_STATS_EN
    output logic [31:0]          botsEmitted,
    output logic [31:0]          batchesEmitted,
    output logic [15:0]          splitCount,
`endif
    output logic                 idle
);

    localparam logic [BATCH_SIZE_W-1:0] MAX_B = BATCH_SIZE_W'(MAX_BATCH_SIZE);

    emitter_state_t            r_state;
    emitter_state_t            w_state_next;
    logic [BATCH_SIZE_W-1:0]   r_count;
    logic [BATCH_SIZE_W-1:0]   w_new_count;
    logic                      w_accept;
    logic                      w_has_bot;
    logic                      w_split;
    logic                      w_last_close;
    logic                      w_done;
    logic                      w_full;
    logic                      w_full_next;

    assign w_accept     = inValid && inReady;
    assign w_has_bot    = |inValidPermutes;
    assign w_new_count  = r_count + {{(BATCH_SIZE_W-1){1'b0}}, w_has_bot};
    assign w_split      = w_accept && w_has_bot && (w_new_count == MAX_B);
    assign w_last_close = w_accept && inLast && (w_new_count != '0);
    assign w_done       = w_split || w_last_close;

    bot_emitter_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CREDIT_W        (CREDIT_W)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_done),
        .i_dec       (batchFinishedIn),
        .o_count     (outstanding),
        .o_full      (w_full),
        .o_full_next (w_full_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stop accepting once the closing batch fills the last credit; any finish pulse reopens
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:         if (w_done && w_full_next) w_state_next = CREDIT_WAIT;
            CREDIT_WAIT: if (batchFinishedIn)       w_state_next = RUN;
            default:     w_state_next = RUN;
        endcase
    end

    // Acceptance: only in RUN, not throttled, and never while reset is held
    always_comb begin
        inReady = rst_n && (r_state == RUN) && !w_full && !slowDownInput;
    end

    // Registered lane write beat; idle cycles present a zero mask and no batch end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outBot           <= '0;
            outValidPermutes <= '0;
            outBatchDone     <= 1'b0;
        end else begin
            if (w_accept) begin
                outBot <= inBot;
            end
            outValidPermutes <= w_accept ? inValidPermutes : '0;
            outBatchDone     <= w_done;
        end
    end

    // Bots in the open batch; cleared by whichever event closes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_done) begin
            r_count <= '0;
        end else if (w_accept && w_has_bot) begin
            r_count <= w_new_count;
        end
    end

`ifdef BOT_EMITTER_STATS_EN
    // Wrapping activity counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            botsEmitted    <= '0;
            batchesEmitted <= '0;
            splitCount     <= '0;
        end else begin
            if (w_accept && w_has_bot) botsEmitted    <= botsEmitted + 32'd1;
            if (w_done)                batchesEmitted <= batchesEmitted + 32'd1;
            if (w_split)               splitCount     <= splitCount + 16'd1;
        end
    end
`endif

    assign idle = (r_state == RUN) && (r_count == '0) && (outstanding == '0)
                  && (outValidPermutes == '0) && !outBatchDone;

endmodule

// File: tb/tb_bot_batch_emitter.sv
// tb/tb_bot_batch_emitter.sv - vector table, directed sequences and random run against a credit/batch model
module tb_bot_batch_emitter;

    localparam int MAXB = 63;
    localparam int MAXO = 2;
    localparam int CW   = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] inBot = '0;
    logic [5:0]   inValidPermutes = '0;
    logic         inLast = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [127:0] outBot;
    logic [5:0]   outValidPermutes;
    logic         outBatchDone;
    logic         slowDownInput = 1'b0;
    logic         batchFinishedIn = 1'b0;
    logic [CW-1:0] outstanding;
    logic         idle;
`ifdef BOT_EMITTER_STATS_EN
    logic [31:0]  botsEmitted;
    logic [31:0]  batchesEmitted;
    logic [15:0]  splitCount;
`endif

    bot_batch_emitter #(
        .MAX_BATCH_SIZE  (MAXB),
        .MAX_OUTSTANDING (MAXO),
        .CREDIT_W        (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .inBot            (inBot),
        .inValidPermutes  (inValidPermutes),
        .inLast           (inLast),
        .inValid          (inValid),
        .inReady          (inReady),
        .outBot           (outBot),
        .outValidPermutes (outValidPermutes),
        .outBatchDone     (outBatchDone),
        .slowDownInput    (slowDownInput),
        .batchFinishedIn  (batchFinishedIn),
        .outstanding      (outstanding),
`ifdef BOT_EMITTER_STATS_EN
        .botsEmitted      (botsEmitted),
        .batchesEmitted   (batchesEmitted),
        .splitCount       (splitCount),
`endif
        .idle             (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           m_cnt, m_oc, m_bots, m_batches, m_splits, writes_seen;
    logic [5:0]   m_mask;
    logic         m_done, m_ready, m_acc;
    logic [127:0] m_bot;
    logic         seen_ready;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_oc = 0; m_mask = '0; m_done = 1'b0; m_bot = '0;
        m_bots = 0; m_batches = 0; m_splits = 0;
    endtask

    // asynchronous reset entered mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        inValid = 1'b1; inValidPermutes = 6'h3F; slowDownInput = 1'b0; batchFinishedIn = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mask", 128'(outValidPermutes), 128'(0));
        chk("rst_done", 128'(outBatchDone), 128'(0));
        chk("rst_bot", outBot, 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        chk("rst_ready", 128'(inReady), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        inValid = 1'b0;
        model_clear();
        #1 chk("post_rst_idle", 128'(idle), 128'(1));
    endtask

    // one clock: drive, predict from batch/credit rules, compare at the next falling edge
    task automatic step(input logic v, input logic [5:0] mask, input logic l, input logic s,
                        input logic f, input logic [127:0] bot);
        logic hb, done, split, dec;
        int nb;
        inValid = v; inValidPermutes = mask; inLast = l; slowDownInput = s;
        batchFinishedIn = f; inBot = bot;
        #1;
        m_ready = !s && (m_oc < MAXO);
        seen_ready = inReady;
        chk("ready", 128'(inReady), 128'(m_ready));
        m_acc = v && m_ready;
        hb = (mask != 0);
        done = 1'b0; split = 1'b0;
        if (m_acc) begin
            nb = m_cnt + (hb ? 1 : 0);
            split = hb && (nb == MAXB);
            done = split || (l && nb > 0);
            m_cnt = done ? 0 : nb;
            m_mask = mask;
            if (hb) begin
                m_bot = bot;
                m_bots++;
            end
        end else begin
            m_mask = '0;
        end
        m_done = done;
        if (done) m_batches++;
        if (split) m_splits++;
        dec = f && (m_oc > 0);
        m_oc = m_oc + (done ? 1 : 0) - (dec ? 1 : 0);
        @(negedge clk);
        chk("out_mask", 128'(outValidPermutes), 128'(m_mask));
        chk("out_done", 128'(outBatchDone), 128'(m_done));
        chk("outstanding", 128'(outstanding), 128'(m_oc));
        chk("idle", 128'(idle), 128'((m_cnt == 0 && m_oc == 0 && m_mask == 0 && !m_done) ? 1 : 0));
        if (m_mask != 0) chk("out_bot", outBot, m_bot);
        if (outValidPermutes != 0) writes_seen++;
    endtask

    // offer one beat until accepted, returning credits only when the block is blocked on them
    task automatic send(input logic [5:0] mask, input logic l, input logic [127:0] bot);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step(1'b1, mask, l, 1'b0, (m_oc == MAXO), bot);
            ok = m_acc;
        end
        if (!ok) chk("send_timeout", 128'(0), 128'(1));
    endtask

    typedef struct {
        logic       v;
        logic [5:0] mask;
        logic       l;
        logic       s;
        logic       f;
        logic       e_ready;
        logic [5:0] e_mask;
        logic       e_done;
        int         e_os;
    } vec_t;

    vec_t vt[12];
    int   done_at[$];
    int   w0;

    initial begin
        vt[0]  = '{1, 6'h3F, 0, 0, 0,  1, 6'h3F, 0, 0};
        vt[1]  = '{1, 6'h01, 0, 0, 0,  1, 6'h01, 0, 0};
        vt[2]  = '{1, 6'h00, 1, 0, 0,  1, 6'h00, 1, 1};
        vt[3]  = '{1, 6'h00, 1, 0, 0,  1, 6'h00, 0, 1};
        vt[4]  = '{0, 6'h3F, 1, 0, 0,  1, 6'h00, 0, 1};
        vt[5]  = '{1, 6'h05, 1, 1, 0,  0, 6'h00, 0, 1};
        vt[6]  = '{1, 6'h05, 1, 0, 0,  1, 6'h05, 1, 2};
        vt[7]  = '{1, 6'h3F, 1, 0, 0,  0, 6'h00, 0, 2};
        vt[8]  = '{1, 6'h3F, 1, 0, 1,  0, 6'h00, 0, 1};
        vt[9]  = '{1, 6'h3F, 1, 0, 1,  1, 6'h3F, 1, 1};
        vt[10] = '{0, 6'h00, 0, 0, 1,  1, 6'h00, 0, 0};
        vt[11] = '{0, 6'h00, 0, 0, 1,  1, 6'h00, 0, 0};

        model_clear();
        writes_seen = 0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            step(vt[i].v, vt[i].mask, vt[i].l, vt[i].s, vt[i].f, {4{32'hA000_0000 + i}});
            chk($sformatf("vec%0d_ready", i), 128'(seen_ready), 128'(vt[i].e_ready));
            chk($sformatf("vec%0d_mask", i), 128'(outValidPermutes), 128'(vt[i].e_mask));
            chk($sformatf("vec%0d_done", i), 128'(outBatchDone), 128'(vt[i].e_done));
            chk($sformatf("vec%0d_os", i), 128'(outstanding), 128'(vt[i].e_os));
            if (vt[i].e_mask != 0) chk($sformatf("vec%0d_bot", i), outBot, {4{32'hA000_0000 + i}});
        end

        // split: 130 bots, last on the final one
        for (int i = 1; i <= 130; i++) begin
            send(6'h3F, (i == 130), 128'(i));
            if (outBatchDone) done_at.push_back(i);
        end
        chk("split_n", 128'(done_at.size()), 128'(3));
        if (done_at.size() == 3) begin
            chk("split_a", 128'(done_at[0]), 128'(63));
            chk("split_b", 128'(done_at[1]), 128'(126));
            chk("split_c", 128'(done_at[2]), 128'(130));
        end
        while (m_oc > 0) step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1, '0);

        // backpressure: 10 throttled cycles mid-batch, nothing accepted, order kept
        w0 = writes_seen;
        for (int i = 0; i < 4; i++) send(6'h2A, 1'b0, 128'(1000 + i));
        for (int i = 0; i < 10; i++) step(1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 128'(2000 + i));
        chk("bp_no_writes", 128'(writes_seen - w0), 128'(4));
        for (int i = 4; i < 8; i++) send(6'h2A, (i == 7), 128'(1000 + i));
        chk("bp_writes", 128'(writes_seen - w0), 128'(8));

        // randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0,
                 (($urandom % 4) == 0) ? 6'h00 : 6'($urandom),
                 ($urandom % 12) == 0,
                 ($urandom % 8) == 0,
                 ($urandom % 5) == 0,
                 {$urandom, $urandom, $urandom, $urandom});
        end

`ifdef BOT_EMITTER_STATS_EN
        chk("stat_bots", 128'(botsEmitted), 128'(m_bots));
        chk("stat_batches", 128'(batchesEmitted), 128'(m_batches));
        chk("stat_splits", 128'(splitCount), 128'(m_splits));
`endif

        // reset mid-batch after 20 bots, then a fresh batch must split exactly at MAXB
        while (m_oc > 0) step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1, '0);
        while (m_cnt > 0) send(6'h00, 1'b1, '0);
        for (int i = 0; i < 20; i++) send(6'h11, 1'b0, 128'(3000 + i));
        do_reset();
        done_at.delete();
        for (int i = 1; i <= MAXB; i++) begin
            send(6'h3F, 1'b0, 128'(4000 + i));
            if (outBatchDone) done_at.push_back(i);
        end
        chk("rst_batch_n", 128'(done_at.size()), 128'(1));
        if (done_at.size() == 1) chk("rst_batch_at", 128'(done_at[0]), 128'(MAXB));
        chk("rst_batch_os", 128'(outstanding), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
